// File: rtl/counter_clock_divider_pkg.sv
// Shared constants and helpers for the counter/clock-divider block:
// seven-segment patterns, DIV_COUNT legality and prescaler sizing.
package counter_clock_divider_pkg;

  // Active-low patterns, bit0=a .. bit6=g, indexed by hex digit.
  localparam logic [6:0] SEG_PATTERNS [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam int unsigned DIV_COUNT_MAX = 32'd16777216;

  function automatic bit div_count_legal(input int unsigned n);
    return (n >= 1) && (n <= DIV_COUNT_MAX);
  endfunction

  function automatic int unsigned presc_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex digit to active-low seven-segment pattern, purely combinational.
module seven_seg_decoder
  import counter_clock_divider_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_PATTERNS[digit_i];

endmodule

// File: rtl/counter_clock_divider.sv
// Prescaler produces a one-cycle enable every DIV_COUNT clocks; a 4-bit
// digit advances on that enable and is shown on a seven-segment display.
module counter_clock_divider
  import counter_clock_divider_pkg::*;
#(
  parameter int unsigned DIV_COUNT = 5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] display
);

  localparam int unsigned     PW         = presc_width(DIV_COUNT);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(DIV_COUNT - 1);

  if (!div_count_legal(DIV_COUNT)) begin : g_illegal_div_count
    $error("counter_clock_divider: DIV_COUNT out of range 1..2^24");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    digit_q, digit_d;
  logic          tick;

  // tick is an enable, not a clock: every flop stays on clk.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (tick) begin
      presc_d = '0;
      digit_d = digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      digit_q <= 4'd0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
    end
  end

  seven_seg_decoder u_decoder (
    .digit_i (digit_q),
    .seg_o   (display)
  );

endmodule

// File: tb/tb_counter_clock_divider.sv
// Directed bench for counter_clock_divider with DIV_COUNT=5 and DIV_COUNT=1.
module tb_counter_clock_divider;

  logic       clk;
  logic       rst5, rst1;
  logic [6:0] display5, display1;

  int n_checks = 0;
  int n_bad    = 0;

  logic [6:0] seg_exp [16];

  counter_clock_divider #(.DIV_COUNT(5)) dut5 (
    .clk     (clk),
    .rst     (rst5),
    .display (display5)
  );

  counter_clock_divider #(.DIV_COUNT(1)) dut1 (
    .clk     (clk),
    .rst     (rst1),
    .display (display1)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    seg_exp = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst5 = 1'b1;
    rst1 = 1'b1;

    // Reset held for two edges.
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("reset5", display5, 7'h40);
      check_val("reset1", display1, 7'h40);
    end

    // Release and run 80 edges: digit = (k/5) mod 16 after edge k.
    rst5 = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      step();
      check_val("run", display5, seg_exp[(k / 5) % 16]);
      check_val("nox", {6'd0, $isunknown(display5)}, 7'd0);
      if (k % 20 == 0) check_val("held1", display1, 7'h40);
    end

    // 38 more edges: 118 total -> digit 7, prescaler 3.
    for (int k = 0; k < 38; k++) step();
    check_val("pre_rst", display5, 7'h78);
    rst5 = 1'b1;
    step();
    check_val("mid_rst", display5, 7'h40);
    rst5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_val("after_mid_rst", display5, (k < 5) ? 7'h40 : 7'h79);
    end

    // Now prescaler 0, digit 1; 4 edges bring prescaler to 4.
    for (int k = 0; k < 4; k++) step();
    check_val("pre_tick_rst", display5, 7'h79);
    rst5 = 1'b1;
    step();
    check_val("rst_over_tick", display5, 7'h40);
    rst5 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      check_val("after_tick_rst", display5, seg_exp[(k / 5) % 16]);
    end

    // DIV_COUNT=1: digit advances on every edge.
    rst1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      check_val("div1", display1, seg_exp[k % 16]);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
